// File: rtl/branch_predictor.sv
// Gshare direction predictor (8-bit GHR XOR PC into a 256 x 2-bit PHT) paired with a
// 16-entry direct-mapped BTB; predictions are combinational, training comes from EX.
module branch_predictor (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_pipeline,
   input  logic        fetch_valid,
   input  logic [15:0] fetch_pc,
   output logic        pred_taken,
   output logic [15:0] pred_target,
   output logic [7:0]  pred_history,
   input  logic        resolve_valid,
   input  logic [15:0] resolve_pc,
   input  logic [7:0]  resolve_history,
   input  logic        resolve_prediction,
   input  logic [15:0] resolve_pred_target,
   input  logic        resolve_taken,
   input  logic [15:0] resolve_target,
   output logic        mispredict
);

   logic [7:0]  ghr;
   logic [1:0]  pht [256];
   logic        btb_valid [16];
   logic [10:0] btb_tag [16];
   logic [15:0] btb_target [16];

   logic [7:0]  fetch_idx;
   logic [3:0]  fetch_btb_idx;
   logic        btb_hit;
   logic [7:0]  res_idx;
   logic [3:0]  res_btb_idx;
   logic [1:0]  res_ctr;
   logic        unused_pc_lsb;

   // Instructions are 2-byte aligned, so bit 0 of either PC never selects anything.
   assign unused_pc_lsb = ^{fetch_pc[0], resolve_pc[0]};

   assign fetch_idx     = fetch_pc[8:1] ^ ghr;
   assign fetch_btb_idx = fetch_pc[4:1];
   assign res_idx       = resolve_pc[8:1] ^ resolve_history;
   assign res_btb_idx   = resolve_pc[4:1];
   assign res_ctr       = pht[res_idx];

   always_comb begin
      btb_hit      = btb_valid[fetch_btb_idx] && (btb_tag[fetch_btb_idx] == fetch_pc[15:5]);
      pred_taken   = btb_hit && pht[fetch_idx][1];
      pred_target  = btb_hit ? btb_target[fetch_btb_idx] : fetch_pc + 16'd2;
      pred_history = ghr;
      mispredict   = resolve_valid &&
                     ((resolve_taken != resolve_prediction) ||
                      (resolve_taken && (resolve_target != resolve_pred_target)));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ghr <= 8'h00;
         for (int i = 0; i < 256; i++) pht[i] <= 2'b01;
         for (int i = 0; i < 16; i++) btb_valid[i] <= 1'b0;
      end else begin
         // Training is independent of stall: EX keeps retiring branches while IF is frozen.
         if (resolve_valid) begin
            if (resolve_taken) begin
               if (res_ctr != 2'b11) pht[res_idx] <= res_ctr + 2'd1;
               btb_valid[res_btb_idx]  <= 1'b1;
               btb_tag[res_btb_idx]    <= resolve_pc[15:5];
               btb_target[res_btb_idx] <= resolve_target;
            end else if (res_ctr != 2'b00) begin
               pht[res_idx] <= res_ctr - 2'd1;
            end
         end
         // Repair from the resolved branch wins over the speculative shift.
         if (mispredict)
            ghr <= {resolve_history[6:0], resolve_taken};
         else if (fetch_valid && !stall_pipeline && btb_hit)
            ghr <= {ghr[6:0], pred_taken};
      end
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 The block SHALL provide these IF-stage ports: stall_pipeline  in  1  pipeline freeze; fetch_valid  in  1  fetch_pc is a real fetch; fetch_pc  in  16  fetch address.
REQ-003 The block SHALL provide these prediction outputs: pred_taken  out  1  predicted taken; pred_target  out  16  predicted target; pred_history  out  8  GHR used for this lookup, carried down the pipeline as branch_history.
REQ-004 The block SHALL provide these resolution inputs from the EX stage: resolve_valid  in  1  one-cycle pulse per resolved branch; resolve_pc  in  16; resolve_history  in  8; resolve_prediction  in  1; resolve_pred_target  in  16; resolve_taken  in  1; resolve_target  in  16.
REQ-005 The block SHALL provide mispredict  out  1  combinational redirect/flush request.

Function
REQ-006 The block SHALL hold an 8-bit global history register (GHR), a 256 x 2-bit pattern history table (PHT) and a 16-entry direct-mapped BTB (valid, 11-bit tag, 16-bit target).
REQ-007 The fetch PHT index SHALL be fetch_pc[8:1] XOR GHR; the BTB index SHALL be fetch_pc[4:1] and the tag fetch_pc[15:5].
REQ-008 btb_hit SHALL equal entry valid AND tag match; pred_taken SHALL equal btb_hit AND PHT[idx][1]; pred_target SHALL equal the BTB target on hit, else fetch_pc+2 (mod 2^16); all three outputs are combinational, zero latency.
REQ-009 pred_history SHALL equal the current GHR value used for the lookup.
REQ-010 mispredict SHALL equal resolve_valid AND ((resolve_taken != resolve_prediction) OR (resolve_taken AND resolve_target != resolve_pred_target)).
REQ-011 On resolve_valid, the PHT entry at resolve_pc[8:1] XOR resolve_history SHALL increment if resolve_taken else decrement, saturating at 2'b11 and 2'b00.
REQ-012 On resolve_valid AND resolve_taken, the BTB entry at resolve_pc[4:1] SHALL be written valid=1, tag=resolve_pc[15:5], target=resolve_target, replacing any prior occupant.
REQ-013 Not-taken resolutions SHALL NOT modify the BTB.
REQ-014 GHR update priority: (1) reset -> 0; (2) mispredict -> {resolve_history[6:0], resolve_taken}; (3) fetch_valid AND NOT stall_pipeline AND btb_hit -> {GHR[6:0], pred_taken}; (4) otherwise hold.
REQ-015 While stall_pipeline=1, GHR SHALL hold (unless mispredict), and resolution updates to PHT/BTB SHALL still be applied.
REQ-016 Simultaneous lookup and update of the same PHT/BTB entry SHALL return the pre-update value; the new value is visible from the next cycle.
REQ-017 A correctly predicted resolution SHALL NOT alter the GHR.

Reset
REQ-018 reset asserted at a rising edge SHALL set GHR=8'h00, all PHT entries=2'b01 (weakly not taken), and all BTB valid bits=0; this SHALL take effect in that one cycle, even mid-operation, and resolve_valid SHALL be ignored during that cycle.
REQ-019 After reset, the combinational outputs SHALL be: pred_taken=0, pred_target=fetch_pc+2, and pred_history=8'h00.

Verification
REQ-020 Reset, then fetch_pc=16'h0040 -> pred_taken=0, pred_target=16'h0042, pred_history=8'h00.
REQ-021 One resolve (pc=16'h0040, history=00, prediction=0, taken=1, target=16'h0100, pred_target=16'h0042) -> mispredict=1 that cycle, GHR=8'h01, BTB[0] valid, PHT[8'h20]=2'b10; a subsequent fetch of 16'h0040 (PHT index 8'h21, still 2'b01) -> pred_taken=0, pred_target=16'h0100.
REQ-022 Four taken resolves on PC 16'h0040 with history 00 -> PHT[8'h20] saturates at 2'b11; two not-taken resolves -> 2'b01; a third -> 2'b00; a fourth stays 2'b00.
REQ-023 BTB hit with fetch_valid=1 and stall_pipeline=1 for 3 cycles -> GHR unchanged; after stall_pipeline drops -> GHR shifts exactly once per hit fetch.
REQ-024 mispredict in the same cycle as a hit fetch with GHR=8'hA5 and resolve_history=8'h3C, taken=0 -> GHR=8'h78 (repair wins over speculative shift).
REQ-025 BTB alias: taken resolves on 16'h0040 then 16'h0060 (same index, different tag), both target 16'h0200 -> fetch of 16'h0040 misses (pred_target=16'h0042), fetch of 16'h0060 hits.
